// File: rtl/vga_timing_out_if.sv
// Raster-side signal bundle for vga_timing_out: pixel request/return and VGA pins.
// The slave modport is the timing generator; the master is the pixel source/sink.
`timescale 1ns/1ps
interface vga_timing_out_if #(
    parameter int BPP = 1,
    parameter int XW  = 10,
    parameter int YW  = 10
);
    logic           enable;
    logic [BPP-1:0] pix_red;
    logic [BPP-1:0] pix_grn;
    logic [BPP-1:0] pix_blu;
    logic [XW-1:0]  xpos;
    logic [YW-1:0]  ypos;
    logic           pix_req;
    logic           line_start;
    logic           frame_start;
    logic [BPP-1:0] vga_red;
    logic [BPP-1:0] vga_grn;
    logic [BPP-1:0] vga_blu;
    logic           vga_hsync;
    logic           vga_vsync;
    logic           vga_active;

    modport slave (
        input  enable, pix_red, pix_grn, pix_blu,
        output xpos, ypos, pix_req, line_start, frame_start,
        output vga_red, vga_grn, vga_blu, vga_hsync, vga_vsync, vga_active
    );

    modport master (
        output enable, pix_red, pix_grn, pix_blu,
        input  xpos, ypos, pix_req, line_start, frame_start,
        input  vga_red, vga_grn, vga_blu, vga_hsync, vga_vsync, vga_active
    );
endinterface

// File: rtl/vga_timing_out.sv
// VGA raster timing generator: position counters, pixel request, and a delay line
// that aligns sync/active with pixel data returned PIPE clocks after the request.
`timescale 1ns/1ps
module vga_timing_out #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter bit HS_NEG   = 1'b1,
    parameter bit VS_NEG   = 1'b1,
    parameter int BPP      = 1,
    parameter int PIPE     = 2
) (
    input  logic              clk,
    input  logic              reset,
    vga_timing_out_if.slave   bus
);
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int XW       = $clog2(H_TOTAL);
    localparam int YW       = $clog2(V_TOTAL);
    localparam int HS_START = H_ACTIVE + H_FRONT;
    localparam int HS_END   = H_ACTIVE + H_FRONT + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FRONT;
    localparam int VS_END   = V_ACTIVE + V_FRONT + V_SYNC;
    localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);

    logic [XW-1:0]  xpos_q;
    logic [YW-1:0]  ypos_q;
    logic           visible;
    logic           act_raw;
    logic           hs_raw;
    logic           vs_raw;
    logic [PIPE:0]  act_sr;
    logic [PIPE:0]  hs_sr;
    logic [PIPE:0]  vs_sr;
    logic [BPP-1:0] red_q;
    logic [BPP-1:0] grn_q;
    logic [BPP-1:0] blu_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xpos_q <= '0;
            ypos_q <= '0;
        end else if (!bus.enable) begin
            xpos_q <= '0;
            ypos_q <= '0;
        end else if (xpos_q == X_LAST) begin
            xpos_q <= '0;
            ypos_q <= (ypos_q == Y_LAST) ? '0 : ypos_q + 1'b1;
        end else begin
            xpos_q <= xpos_q + 1'b1;
        end
    end

    // Raw timing is gated by enable so a disabled raster drains to blank.
    always_comb begin
        visible = (int'(xpos_q) < H_ACTIVE) && (int'(ypos_q) < V_ACTIVE);
        act_raw = bus.enable && visible;
        hs_raw  = bus.enable && (int'(xpos_q) >= HS_START) && (int'(xpos_q) < HS_END);
        vs_raw  = bus.enable && (int'(ypos_q) >= VS_START) && (int'(ypos_q) < VS_END);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_sr <= '0;
            hs_sr  <= '0;
            vs_sr  <= '0;
        end else begin
            act_sr <= {act_sr[PIPE-1:0], act_raw};
            hs_sr  <= {hs_sr[PIPE-1:0], hs_raw};
            vs_sr  <= {vs_sr[PIPE-1:0], vs_raw};
        end
    end

    // Stage PIPE-1 holds the active bit of the request whose data arrives this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            red_q <= '0;
            grn_q <= '0;
            blu_q <= '0;
        end else if (act_sr[PIPE-1]) begin
            red_q <= bus.pix_red;
            grn_q <= bus.pix_grn;
            blu_q <= bus.pix_blu;
        end else begin
            red_q <= '0;
            grn_q <= '0;
            blu_q <= '0;
        end
    end

    assign bus.xpos        = xpos_q;
    assign bus.ypos        = ypos_q;
    assign bus.pix_req     = visible;
    assign bus.line_start  = bus.enable && !reset && (xpos_q == '0);
    assign bus.frame_start = bus.enable && !reset && (xpos_q == '0) && (ypos_q == '0);
    assign bus.vga_red     = red_q;
    assign bus.vga_grn     = grn_q;
    assign bus.vga_blu     = blu_q;
    assign bus.vga_active  = act_sr[PIPE];
    assign bus.vga_hsync   = hs_sr[PIPE] ^ HS_NEG;
    assign bus.vga_vsync   = vs_sr[PIPE] ^ VS_NEG;
endmodule

// File: doc/vga_timing_out.md
VGA_TIMING_OUT -- requirements
Module: vga_timing_out

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FRONT, H_SYNC, H_BACK with defaults 16, 96, 48, giving horizontal porch and sync lengths in clocks.
REQ-003 SHALL have parameters V_ACTIVE, V_FRONT, V_SYNC, V_BACK with defaults 480, 10, 2, 33, giving vertical lines.
REQ-004 SHALL have parameters HS_NEG and VS_NEG, default 1, meaning the sync is active-low when set.
REQ-005 SHALL have parameter BPP, default 1, giving bits per colour channel.
REQ-006 SHALL have parameter PIPE, default 2, the pixel-source latency in clocks (1..8).
REQ-007 SHALL have port clk, input, 1 bit: the pixel clock and the only clock.
REQ-008 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-009 SHALL have port enable, input, 1 bit: run the raster when high.
REQ-010 SHALL have ports pix_red, pix_grn, pix_blu, input, BPP bits each: pixel data returned PIPE clocks after the request.
REQ-011 SHALL have ports xpos and ypos, output, clog2(H_TOTAL) and clog2(V_TOTAL) bits: the current raster position, i.e. the request address.
REQ-012 SHALL have port pix_req, output, 1 bit: the current position is visible.
REQ-013 SHALL have ports line_start and frame_start, output, 1 bit each: one-clock pulses.
REQ-014 SHALL have ports vga_red, vga_grn, vga_blu, output, BPP bits each; and vga_hsync, vga_vsync, vga_active, output, 1 bit each.

Function
REQ-015 Definitions: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL is defined likewise.
REQ-016 While enable is high, xpos SHALL increment every clock and wrap H_TOTAL-1 -> 0.
REQ-017 On the x wrap, ypos SHALL increment; ypos SHALL wrap V_TOTAL-1 -> 0.
REQ-018 While enable is low, xpos and ypos SHALL be forced to 0 on each clock.
REQ-019 pix_req SHALL be combinational from the registered counters: (xpos < H_ACTIVE) and (ypos < V_ACTIVE).
REQ-020 line_start SHALL be 1 when enable=1 and xpos=0.
REQ-021 frame_start SHALL be 1 when enable=1, xpos=0 and ypos=0.
REQ-022 Raw hsync SHALL be true for H_ACTIVE+H_FRONT <= xpos < H_ACTIVE+H_FRONT+H_SYNC.
REQ-023 Raw vsync SHALL be true for V_ACTIVE+V_FRONT <= ypos < V_ACTIVE+V_FRONT+V_SYNC.
REQ-024 Output polarity: pin value = raw XOR HS_NEG (resp. VS_NEG).
REQ-025 Raw active, hsync and vsync from cycle t SHALL pass through a PIPE+1 stage shift register, so they appear on vga_active, vga_hsync and vga_vsync at cycle t+PIPE+1.
REQ-026 pix_* SHALL be sampled at cycle t+PIPE and registered onto vga_red, vga_grn and vga_blu at t+PIPE+1, aligned with vga_active.
REQ-027 Colour outputs SHALL be 0 whenever the aligned active bit is 0 (blanking), regardless of pix_* values.
REQ-028 When enable is low, the delay line SHALL shift in raw active=0, hsync=0, vsync=0, so outputs drain to blank/deasserted within PIPE+1 clocks.
REQ-029 Deasserting enable mid-line SHALL produce no partial-line glitch beyond the drain in REQ-028.
REQ-030 Reasserting enable SHALL restart at (0,0) with a frame_start pulse on the first enabled cycle.
REQ-031 Simultaneous x and y wrap SHALL yield (0,0) in one clock, with no skipped or duplicated line.
REQ-032 All outputs except pix_req, line_start and frame_start SHALL be registered.

Reset
REQ-033 Asserting reset SHALL asynchronously clear xpos, ypos and all delay-line stages, and set vga_red/grn/blu, vga_active, line_start and frame_start to 0.
REQ-034 During reset, vga_hsync SHALL equal HS_NEG and vga_vsync SHALL equal VS_NEG (sync deasserted).
REQ-035 After reset release with enable=1, the first clock edge SHALL advance xpos 0 -> 1, and frame_start SHALL be high before that edge.

Verification (small params: H 8/2/2/2 => H_TOTAL 14, V 4/1/1/1 => V_TOTAL 7, PIPE 2, BPP 1, HS_NEG=VS_NEG=1)
REQ-036 Free run, 2 frames -> frame_start period 98 clocks; line_start period 14; vga_hsync low exactly 2 clocks per line, starting 3 clocks after xpos=10.
REQ-037 Drive pix_red = xpos[0] delayed 2 clocks -> vga_red pattern 0,1,0,1,0,1,0,1 per visible line, aligned with vga_active, and 0 during blanking.
REQ-038 Hold pix_* = 1 constantly -> colours high only on 8 clocks/line for ypos 0..3; colours 0 on lines 4..6; vga_vsync low for exactly 14 clocks (line 5).
REQ-039 Drop enable at xpos=5, ypos=2 -> xpos/ypos = 0 next clock; vga_active = 0 within 3 clocks; re-enable gives frame_start on the first cycle.
REQ-040 Assert reset asynchronously mid-line (between edges) -> outputs immediately at reset values (REQ-033/034); after release, the raster restarts at (0,0).
REQ-041 Run with BPP=2 and HS_NEG=0 -> 2-bit colours pass unchanged; hsync is active-high for 2 clocks/line.
